// File: rtl/nasti_mem_tester_if.sv
// nasti_channel: single NASTI (AXI4) channel bundle between one master and one slave.
interface nasti_channel #(
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 128,
    parameter int USER_WIDTH = 1
);
    logic [ID_WIDTH-1:0]     aw_id;
    logic [ADDR_WIDTH-1:0]   aw_addr;
    logic [7:0]              aw_len;
    logic [2:0]              aw_size;
    logic [1:0]              aw_burst;
    logic                    aw_lock;
    logic [3:0]              aw_cache;
    logic [2:0]              aw_prot;
    logic [3:0]              aw_qos;
    logic [3:0]              aw_region;
    logic [USER_WIDTH-1:0]   aw_user;
    logic                    aw_valid;
    logic                    aw_ready;
    logic [DATA_WIDTH-1:0]   w_data;
    logic [DATA_WIDTH/8-1:0] w_strb;
    logic                    w_last;
    logic [USER_WIDTH-1:0]   w_user;
    logic                    w_valid;
    logic                    w_ready;
    logic [ID_WIDTH-1:0]     b_id;
    logic [1:0]              b_resp;
    logic [USER_WIDTH-1:0]   b_user;
    logic                    b_valid;
    logic                    b_ready;
    logic [ID_WIDTH-1:0]     ar_id;
    logic [ADDR_WIDTH-1:0]   ar_addr;
    logic [7:0]              ar_len;
    logic [2:0]              ar_size;
    logic [1:0]              ar_burst;
    logic                    ar_lock;
    logic [3:0]              ar_cache;
    logic [2:0]              ar_prot;
    logic [3:0]              ar_qos;
    logic [3:0]              ar_region;
    logic [USER_WIDTH-1:0]   ar_user;
    logic                    ar_valid;
    logic                    ar_ready;
    logic [ID_WIDTH-1:0]     r_id;
    logic [DATA_WIDTH-1:0]   r_data;
    logic [1:0]              r_resp;
    logic                    r_last;
    logic [USER_WIDTH-1:0]   r_user;
    logic                    r_valid;
    logic                    r_ready;

    modport master (
        output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        input  aw_ready,
        output w_data, w_strb, w_last, w_user, w_valid,
        input  w_ready,
        input  b_id, b_resp, b_user, b_valid,
        output b_ready,
        output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        input  ar_ready,
        input  r_id, r_data, r_resp, r_last, r_user, r_valid,
        output r_ready
    );

    modport slave (
        input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_lock, aw_cache, aw_prot,
               aw_qos, aw_region, aw_user, aw_valid,
        output aw_ready,
        input  w_data, w_strb, w_last, w_user, w_valid,
        output w_ready,
        output b_id, b_resp, b_user, b_valid,
        input  b_ready,
        input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_lock, ar_cache, ar_prot,
               ar_qos, ar_region, ar_user, ar_valid,
        output ar_ready,
        output r_id, r_data, r_resp, r_last, r_user, r_valid,
        input  r_ready
    );
endinterface

// File: rtl/nasti_mem_tester.sv
// nasti_mem_tester: NASTI master BIST that writes address-derived bursts, reads them back and checks every beat.
module nasti_mem_tester #(
    parameter int              ID_WIDTH   = 1,
    parameter int              ADDR_WIDTH = 16,
    parameter int              DATA_WIDTH = 128,
    parameter int              USER_WIDTH = 1,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = '0,
    parameter int              NUM_BURSTS = 4,
    parameter int              BURST_LEN  = 8,
    parameter logic [31:0]     SEED       = 32'hA5A5_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic        resp_err,
    output logic        proto_err,
    nasti_channel.master nasti
);
    localparam int SIZE = $clog2(DATA_WIDTH / 8);
    localparam logic [ADDR_WIDTH-1:0] BURST_BYTES = ADDR_WIDTH'(BURST_LEN * (DATA_WIDTH / 8));
    localparam logic [15:0] LAST_BURST = 16'(NUM_BURSTS - 1);
    localparam logic [7:0]  LAST_BEAT  = 8'(BURST_LEN - 1);

    if (DATA_WIDTH % 32 != 0 || DATA_WIDTH > 256 || NUM_BURSTS < 1 || NUM_BURSTS > 65535 ||
        BURST_LEN < 1 || BURST_LEN > 256) begin : g_bad_params
        $error("nasti_mem_tester: illegal DATA_WIDTH, NUM_BURSTS or BURST_LEN");
    end

    typedef enum logic [2:0] {S_IDLE, S_AW, S_W, S_B, S_AR, S_R, S_DONE} state_t;

    state_t                  state, state_nx;
    logic                    aw_valid, w_valid, b_ready, ar_valid, r_ready;
    logic [7:0]              beat_cnt;
    logic [15:0]             burst_cnt;
    logic [ADDR_WIDTH-1:0]   burst_addr, beat_addr;
    logic [DATA_WIDTH-1:0]   pattern;
    logic                    aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last, r_end, last_burst, start_acc;
    logic [15:0]             err_nx;
    logic                    resp_nx, proto_nx;

    assign aw_hs      = aw_valid & nasti.aw_ready;
    assign w_hs       = w_valid & nasti.w_ready;
    assign b_hs       = b_ready & nasti.b_valid;
    assign ar_hs      = ar_valid & nasti.ar_ready;
    assign r_hs       = r_ready & nasti.r_valid;
    assign w_last     = beat_cnt == LAST_BEAT;
    // an early r_last still closes the burst so the sequence cannot stall on a faulty slave
    assign r_end      = r_hs & (w_last | nasti.r_last);
    assign last_burst = burst_cnt == LAST_BURST;
    assign start_acc  = start & (state == S_IDLE || state == S_DONE);
    assign beat_addr  = burst_addr + (ADDR_WIDTH'(beat_cnt) << SIZE);
    assign pattern    = {(DATA_WIDTH / 32){32'(beat_addr) ^ SEED}};

    assign err_nx   = start_acc ? 16'd0 :
                      (r_hs && nasti.r_data != pattern && err_count != 16'hFFFF) ? err_count + 16'd1 : err_count;
    assign resp_nx  = !start_acc & (resp_err | (b_hs & (nasti.b_resp != 2'b00)) | (r_hs & (nasti.r_resp != 2'b00)));
    assign proto_nx = !start_acc & (proto_err |
                      (r_hs & ((nasti.r_last != w_last) | (nasti.r_id != {ID_WIDTH{1'b0}}))));

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE, S_DONE: state_nx = start ? S_AW : state;
            S_AW:           state_nx = aw_hs ? S_W : state;
            S_W:            state_nx = (w_hs && w_last) ? S_B : state;
            S_B:            state_nx = b_hs ? (last_burst ? S_AR : S_AW) : state;
            S_AR:           state_nx = ar_hs ? S_R : state;
            S_R:            state_nx = r_end ? (last_burst ? S_DONE : S_AR) : state;
            default:        state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= S_IDLE;
        else       state <= state_nx;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            aw_valid   <= 1'b0;
            w_valid    <= 1'b0;
            b_ready    <= 1'b0;
            ar_valid   <= 1'b0;
            r_ready    <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            pass       <= 1'b0;
            err_count  <= 16'd0;
            resp_err   <= 1'b0;
            proto_err  <= 1'b0;
            beat_cnt   <= 8'd0;
            burst_cnt  <= 16'd0;
            burst_addr <= BASE_ADDR;
        end else begin
            aw_valid  <= state_nx == S_AW;
            w_valid   <= state_nx == S_W;
            b_ready   <= state_nx == S_B;
            ar_valid  <= state_nx == S_AR;
            r_ready   <= state_nx == S_R;
            busy      <= !(state_nx == S_IDLE || state_nx == S_DONE);
            done      <= state_nx == S_DONE;
            pass      <= state_nx == S_DONE && err_nx == 16'd0 && !resp_nx && !proto_nx;
            err_count <= err_nx;
            resp_err  <= resp_nx;
            proto_err <= proto_nx;
            if (w_hs || r_hs) beat_cnt <= ((w_hs && w_last) || r_end) ? 8'd0 : beat_cnt + 8'd1;
            if (b_hs || r_end) begin
                burst_cnt  <= last_burst ? 16'd0 : burst_cnt + 16'd1;
                burst_addr <= last_burst ? BASE_ADDR : burst_addr + BURST_BYTES;
            end
        end
    end

    assign nasti.aw_id     = {ID_WIDTH{1'b0}};
    assign nasti.aw_addr   = burst_addr;
    assign nasti.aw_len    = LAST_BEAT;
    assign nasti.aw_size   = 3'(SIZE);
    assign nasti.aw_burst  = 2'b01;
    assign nasti.aw_lock   = 1'b0;
    assign nasti.aw_cache  = 4'd0;
    assign nasti.aw_prot   = 3'd0;
    assign nasti.aw_qos    = 4'd0;
    assign nasti.aw_region = 4'd0;
    assign nasti.aw_user   = {USER_WIDTH{1'b0}};
    assign nasti.aw_valid  = aw_valid;
    assign nasti.w_data    = pattern;
    assign nasti.w_strb    = '1;
    assign nasti.w_last    = w_last;
    assign nasti.w_user    = {USER_WIDTH{1'b0}};
    assign nasti.w_valid   = w_valid;
    assign nasti.b_ready   = b_ready;
    assign nasti.ar_id     = {ID_WIDTH{1'b0}};
    assign nasti.ar_addr   = burst_addr;
    assign nasti.ar_len    = LAST_BEAT;
    assign nasti.ar_size   = 3'(SIZE);
    assign nasti.ar_burst  = 2'b01;
    assign nasti.ar_lock   = 1'b0;
    assign nasti.ar_cache  = 4'd0;
    assign nasti.ar_prot   = 3'd0;
    assign nasti.ar_qos    = 4'd0;
    assign nasti.ar_region = 4'd0;
    assign nasti.ar_user   = {USER_WIDTH{1'b0}};
    assign nasti.ar_valid  = ar_valid;
    assign nasti.r_ready   = r_ready;
endmodule

// File: tb/tb_nasti_mem_tester.sv
// tb_nasti_mem_tester: randomized memory-slave bench for nasti_mem_tester with fault injection.
module tb_nasti_mem_tester;
    logic clk = 1'b0, rstn = 1'b1, start = 1'b0;
    logic busy, done, pass, resp_err, proto_err;
    logic [15:0] err_count;
    int n_chk = 0, n_err = 0;

    always #5 clk = ~clk;

    nasti_channel #(.ID_WIDTH(1), .ADDR_WIDTH(16), .DATA_WIDTH(128), .USER_WIDTH(1)) ch ();

    nasti_mem_tester dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .resp_err(resp_err), .proto_err(proto_err), .nasti(ch)
    );

    task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [127:0] pat(input logic [15:0] a);
        return {4{{16'h0, a} ^ 32'hA5A5_0000}};
    endfunction

    // slave knobs and reference bookkeeping
    bit          stall, early;
    logic [31:0] cmask;
    int          bad_b;
    int          aw_n = 0, w_n = 0, b_n = 0, ar_n = 0, r_n = 0;
    int          aw0, w0, b0, ar0, r0;
    logic [127:0] mem [0:4095];
    logic [15:0] wr_addr, rd_addr, aw_prev;
    logic [127:0] w_prev;
    logic        aw_hold, w_hold;

    function automatic logic [127:0] rd_data(input logic [15:0] a);
        return mem[a[15:4]] ^ {127'h0, (a[15:4] < 12'd32) && cmask[a[8:4]]};
    endfunction

    function automatic logic rd_last(input logic [15:0] a);
        return a[6:4] == 3'd7 || (early && a[15:4] == 12'd5);
    endfunction

    always @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ch.aw_ready <= 1'b0; ch.w_ready <= 1'b0; ch.ar_ready <= 1'b0;
            ch.b_valid <= 1'b0; ch.b_resp <= 2'b00; ch.b_id <= 1'b0; ch.b_user <= 1'b0;
            ch.r_valid <= 1'b0; ch.r_resp <= 2'b00; ch.r_id <= 1'b0; ch.r_user <= 1'b0;
            ch.r_last <= 1'b0; ch.r_data <= '0;
            aw_hold <= 1'b0; w_hold <= 1'b0;
        end else begin
            ch.aw_ready <= !stall || $urandom_range(0, 3) == 0;
            ch.w_ready  <= !stall || $urandom_range(0, 3) == 0;
            ch.ar_ready <= !stall || $urandom_range(0, 3) == 0;
            if (aw_hold) chk("aw_stable", {ch.aw_valid, ch.aw_addr}, {1'b1, aw_prev});
            if (w_hold) begin
                chk("w_stable_valid", ch.w_valid, 1'b1);
                chk("w_stable_data", ch.w_data, w_prev);
            end
            aw_hold <= ch.aw_valid && !ch.aw_ready;
            aw_prev <= ch.aw_addr;
            w_hold  <= ch.w_valid && !ch.w_ready;
            w_prev  <= ch.w_data;
            if (ch.aw_valid && ch.aw_ready) begin
                chk("aw_addr", ch.aw_addr, 16'(((aw_n - aw0) % 4) * 128));
                chk("aw_len", ch.aw_len, 7);
                chk("aw_size", ch.aw_size, 4);
                chk("aw_burst", ch.aw_burst, 1);
                wr_addr <= ch.aw_addr;
                aw_n <= aw_n + 1;
            end
            if (ch.w_valid && ch.w_ready) begin
                chk("w_data", ch.w_data, pat(wr_addr));
                chk("w_last", ch.w_last, wr_addr[6:4] == 3'd7);
                chk("w_strb", ch.w_strb, 16'hFFFF);
                mem[wr_addr[15:4]] <= ch.w_data;
                wr_addr <= wr_addr + 16'd16;
                w_n <= w_n + 1;
                if (ch.w_last) begin
                    ch.b_valid <= 1'b1;
                    ch.b_resp <= (int'(wr_addr[15:7]) == bad_b) ? 2'b10 : 2'b00;
                end
            end
            if (ch.b_valid && ch.b_ready) begin
                ch.b_valid <= 1'b0;
                b_n <= b_n + 1;
            end
            if (ch.ar_valid && ch.ar_ready) begin
                chk("ar_addr", ch.ar_addr, 16'(((ar_n - ar0) % 4) * 128));
                chk("ar_len", ch.ar_len, 7);
                rd_addr <= ch.ar_addr;
                ch.r_valid <= 1'b1;
                ch.r_data <= rd_data(ch.ar_addr);
                ch.r_last <= rd_last(ch.ar_addr);
                ar_n <= ar_n + 1;
            end
            if (ch.r_valid && ch.r_ready) begin
                r_n <= r_n + 1;
                if (ch.r_last) ch.r_valid <= 1'b0;
                else begin
                    rd_addr <= rd_addr + 16'd16;
                    ch.r_data <= rd_data(rd_addr + 16'd16);
                    ch.r_last <= rd_last(rd_addr + 16'd16);
                end
            end
        end
    end

    task automatic snap();
        aw0 = aw_n; w0 = w_n; b0 = b_n; ar0 = ar_n; r0 = r_n;
    endtask

    task automatic run(input string name, input bit st, input logic [31:0] m, input int bb, input bit el);
        bit exp_resp, exp_proto;
        int exp_err;
        stall = st; cmask = m; bad_b = bb; early = el;
        exp_err = $countones(m);
        exp_resp = bb >= 0 && bb < 4;
        exp_proto = el;
        snap();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        chk({name, ":busy_on"}, busy, 1'b1);
        chk({name, ":done_clr"}, done, 1'b0);
        repeat (7) @(negedge clk);
        start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 20000 && !done; i++) @(negedge clk);
        chk({name, ":done"}, done, 1'b1);
        chk({name, ":busy_off"}, busy, 1'b0);
        chk({name, ":err_count"}, err_count, 16'(exp_err));
        chk({name, ":resp_err"}, resp_err, exp_resp);
        chk({name, ":proto_err"}, proto_err, exp_proto);
        chk({name, ":pass"}, pass, exp_err == 0 && !exp_resp && !exp_proto);
        chk({name, ":n_aw"}, aw_n - aw0, 4);
        chk({name, ":n_w"}, w_n - w0, 32);
        chk({name, ":n_b"}, b_n - b0, 4);
        chk({name, ":n_ar"}, ar_n - ar0, 4);
        chk({name, ":n_r"}, r_n - r0, el ? 30 : 32);
    endtask

    initial begin
        stall = 1'b0; early = 1'b0; cmask = '0; bad_b = -1;
        #1 rstn = 1'b0;
        #1;
        chk("rst_valids", {ch.aw_valid, ch.w_valid, ch.b_ready, ch.ar_valid, ch.r_ready}, 0);
        chk("rst_flags", {busy, done, pass, resp_err, proto_err}, 0);
        chk("rst_err_count", err_count, 0);
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        run("basic", 1'b0, 32'h0, -1, 1'b0);
        run("corrupt", 1'b0, (32'h1 << 3) | (32'h1 << 17), -1, 1'b0);
        run("bresp", 1'b0, 32'h0, 1, 1'b0);
        run("stall", 1'b1, 32'h0, -1, 1'b0);
        run("early", 1'b0, 32'h0, -1, 1'b1);
        for (int k = 0; k < 6; k++) begin
            logic [31:0] m;
            bit el;
            m = $urandom;
            el = 1'($urandom_range(0, 1));
            if (el) m[7:6] = 2'b00;
            run("rand", 1'($urandom_range(0, 1)), m, int'($urandom_range(0, 5)) - 1, el);
        end
        stall = 1'b0; cmask = '0; bad_b = -1; early = 1'b0;
        snap();
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
        for (int i = 0; i < 2000 && !(aw_n - aw0 == 3 && ch.w_valid); i++) @(negedge clk);
        chk("rst_mid:reached_w2", {aw_n - aw0 == 3, ch.w_valid}, 2'b11);
        #2 rstn = 1'b0;
        #1;
        chk("rst_mid:valids", {ch.aw_valid, ch.w_valid, ch.b_ready, ch.ar_valid, ch.r_ready}, 0);
        chk("rst_mid:flags", {busy, done, pass, resp_err, proto_err}, 0);
        chk("rst_mid:err_count", err_count, 0);
        repeat (2) @(negedge clk);
        rstn = 1'b1;
        run("post_rst", 1'b0, 32'h0, -1, 1'b0);
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", n_chk, n_err);
        $fatal(1);
    end
endmodule
